// File: rtl/data_sram_like_slave.sv
// SRAM-like data-port responder: word RAM plus an in-order response queue.
// Every accepted request completes with data_ok exactly LATENCY cycles later.
module data_sram_like_slave #(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 2,
   parameter int QDEPTH  = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        data_sram_req,
   input  logic        data_sram_wr,
   input  logic [1:0]  data_sram_size,
   input  logic [3:0]  data_sram_wstrb,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic        data_sram_addr_ok,
   output logic        data_sram_data_ok,
   output logic [31:0] data_sram_rdata
);

   localparam int PW = $clog2(QDEPTH);
   localparam int CW = 4;
   localparam logic [CW-1:0] CD_INIT = CW'(LATENCY - 1);
   localparam logic [PW:0] FULL = (PW+1)'(QDEPTH);
   // With LATENCY 1 the response leaves on the accept edge, so the queue is bypassed.
   localparam logic BYPASS = 1'(LATENCY == 1);

   logic [31:0]       ram_q  [2**ADDR_W];
   logic [31:0]       snap_q [QDEPTH];
   logic              isrd_q [QDEPTH];
   logic [CW-1:0]     cd_q   [QDEPTH];
   logic [PW-1:0]     head_q, tail_q;
   logic [PW:0]       count_q, count_d;
   logic              dok_q, dok_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [ADDR_W-1:0] idx;
   logic [31:0]       rd_word;
   logic              accept, push, retire, qpop;
   logic              unused_bits;

   assign idx               = data_sram_addr[ADDR_W+1:2];
   assign data_sram_addr_ok = (count_q != FULL);
   assign accept            = resetn & data_sram_req & data_sram_addr_ok;
   assign push              = accept & ~BYPASS;
   assign qpop              = retire & ~BYPASS;
   assign rd_word           = ram_q[idx];
   assign data_sram_data_ok = dok_q;
   assign data_sram_rdata   = rdata_q;
   assign unused_bits       = ^{data_sram_size, data_sram_addr[31:ADDR_W+2],
                                data_sram_addr[1:0]};

   // Retire decision: head entry whose countdown expires this cycle responds next cycle.
   always_comb begin
      retire  = 1'b0;
      dok_d   = 1'b0;
      rdata_d = '0;
      count_d = count_q;
      if (BYPASS) begin
         if (accept) begin
            retire  = 1'b1;
            dok_d   = 1'b1;
            rdata_d = data_sram_wr ? 32'h0 : rd_word;
         end
      end else if (count_q != '0 && cd_q[head_q] <= CW'(1)) begin
         retire  = 1'b1;
         dok_d   = 1'b1;
         rdata_d = isrd_q[head_q] ? snap_q[head_q] : 32'h0;
      end
      if (push && !qpop) begin
         count_d = count_q + (PW+1)'(1);
      end else if (!push && qpop) begin
         count_d = count_q - (PW+1)'(1);
      end
   end

   // Queue control, countdowns and registered response outputs.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         dok_q   <= 1'b0;
         rdata_q <= '0;
         for (int i = 0; i < QDEPTH; i++) begin
            cd_q[i] <= '0;
         end
      end else begin
         count_q <= count_d;
         dok_q   <= dok_d;
         rdata_q <= rdata_d;
         for (int i = 0; i < QDEPTH; i++) begin
            if (cd_q[i] != '0) begin
               cd_q[i] <= cd_q[i] - CW'(1);
            end
         end
         if (push) begin
            cd_q[tail_q] <= CD_INIT;
            tail_q       <= tail_q + PW'(1);
         end
         if (qpop) begin
            head_q <= head_q + PW'(1);
         end
      end
   end

   // Queue payload: read snapshot taken at accept, before this edge's RAM update.
   always_ff @(posedge clk) begin
      if (push) begin
         snap_q[tail_q] <= rd_word;
         isrd_q[tail_q] <= ~data_sram_wr;
      end
   end

   // Byte-lane RAM write; contents survive reset.
   always_ff @(posedge clk) begin
      if (accept && data_sram_wr) begin
         for (int i = 0; i < 4; i++) begin
            if (data_sram_wstrb[i]) begin
               ram_q[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
            end
         end
      end
   end

endmodule
